// File: rtl/decode_ctrl_stage_pkg.sv
// Shared encodings and the control bundle for the RV32 main-control decode stage.
// The bundle field order matches the decode table columns so it reads left to right.
package decode_ctrl_stage_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } imm_src_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10,
        RES_IMM = 2'b11
    } result_src_e;

    typedef enum logic [1:0] {
        ALU_ADD    = 2'b00,
        ALU_BRANCH = 2'b01,
        ALU_FUNCT  = 2'b10,
        ALU_MULDIV = 2'b11
    } alu_op_e;

    typedef struct packed {
        logic        reg_write;
        imm_src_e    imm_src;
        logic        alu_src;
        logic        alu_src_a;
        logic        mem_write;
        result_src_e result_src;
        logic        branch;
        alu_op_e     alu_op;
        logic        jump;
        logic        jump_reg;
    } ctrl_t;

    localparam ctrl_t CTRL_LOAD = '{reg_write: 1'b1, imm_src: IMM_I, alu_src: 1'b1, alu_src_a: 1'b0,
        mem_write: 1'b0, result_src: RES_MEM, branch: 1'b0, alu_op: ALU_ADD, jump: 1'b0, jump_reg: 1'b0};
    localparam ctrl_t CTRL_STORE = '{reg_write: 1'b0, imm_src: IMM_S, alu_src: 1'b1, alu_src_a: 1'b0,
        mem_write: 1'b1, result_src: RES_ALU, branch: 1'b0, alu_op: ALU_ADD, jump: 1'b0, jump_reg: 1'b0};
    localparam ctrl_t CTRL_RTYPE = '{reg_write: 1'b1, imm_src: IMM_I, alu_src: 1'b0, alu_src_a: 1'b0,
        mem_write: 1'b0, result_src: RES_ALU, branch: 1'b0, alu_op: ALU_FUNCT, jump: 1'b0, jump_reg: 1'b0};
    localparam ctrl_t CTRL_MULDIV = '{reg_write: 1'b1, imm_src: IMM_I, alu_src: 1'b0, alu_src_a: 1'b0,
        mem_write: 1'b0, result_src: RES_ALU, branch: 1'b0, alu_op: ALU_MULDIV, jump: 1'b0, jump_reg: 1'b0};
    localparam ctrl_t CTRL_BRANCH = '{reg_write: 1'b0, imm_src: IMM_B, alu_src: 1'b0, alu_src_a: 1'b0,
        mem_write: 1'b0, result_src: RES_ALU, branch: 1'b1, alu_op: ALU_BRANCH, jump: 1'b0, jump_reg: 1'b0};
    localparam ctrl_t CTRL_IALU = '{reg_write: 1'b1, imm_src: IMM_I, alu_src: 1'b1, alu_src_a: 1'b0,
        mem_write: 1'b0, result_src: RES_ALU, branch: 1'b0, alu_op: ALU_FUNCT, jump: 1'b0, jump_reg: 1'b0};
    localparam ctrl_t CTRL_JAL = '{reg_write: 1'b1, imm_src: IMM_J, alu_src: 1'b0, alu_src_a: 1'b0,
        mem_write: 1'b0, result_src: RES_PC4, branch: 1'b0, alu_op: ALU_ADD, jump: 1'b1, jump_reg: 1'b0};
    localparam ctrl_t CTRL_JALR = '{reg_write: 1'b1, imm_src: IMM_I, alu_src: 1'b1, alu_src_a: 1'b0,
        mem_write: 1'b0, result_src: RES_PC4, branch: 1'b0, alu_op: ALU_ADD, jump: 1'b1, jump_reg: 1'b1};
    localparam ctrl_t CTRL_LUI = '{reg_write: 1'b1, imm_src: IMM_U, alu_src: 1'b0, alu_src_a: 1'b0,
        mem_write: 1'b0, result_src: RES_IMM, branch: 1'b0, alu_op: ALU_ADD, jump: 1'b0, jump_reg: 1'b0};
    localparam ctrl_t CTRL_AUIPC = '{reg_write: 1'b1, imm_src: IMM_U, alu_src: 1'b1, alu_src_a: 1'b1,
        mem_write: 1'b0, result_src: RES_ALU, branch: 1'b0, alu_op: ALU_ADD, jump: 1'b0, jump_reg: 1'b0};

    // funct3 010/011 have no branch meaning in RV32I
    function automatic logic branch_f3_bad(input logic [2:0] f3);
        return (f3 == 3'b010) || (f3 == 3'b011);
    endfunction

endpackage

// File: rtl/decode_ctrl_stage_if.sv
// Handshake bus of the decode stage: IF/ID side (instr in) and ID/EX side (control bundle out).
interface decode_ctrl_stage_if #(
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      instr;
    logic [PC_W-1:0]  in_pc;

    logic             out_valid;
    logic             out_ready;
    logic [PC_W-1:0]  out_pc;
    logic [2:0]       out_funct3;

    logic             RegWrite;
    logic             MemWrite;
    logic             Branch;
    logic             Jump;
    logic             JumpReg;
    logic             ALUSrc;
    logic             ALUSrcA;
    logic [1:0]       ResultSrc;
    logic [2:0]       ImmSrc;
    logic [1:0]       ALUOp;

    logic             illegal;
    logic             illegal_sticky;
    logic [CNT_W-1:0] decode_count;

    modport slave (
        input  in_valid, instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_funct3,
               RegWrite, MemWrite, Branch, Jump, JumpReg, ALUSrc, ALUSrcA,
               ResultSrc, ImmSrc, ALUOp, illegal, illegal_sticky, decode_count
    );

    modport master (
        output in_valid, instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_funct3,
               RegWrite, MemWrite, Branch, Jump, JumpReg, ALUSrc, ALUSrcA,
               ResultSrc, ImmSrc, ALUOp, illegal, illegal_sticky, decode_count
    );
endinterface

// File: rtl/decode_ctrl_stage_ctrl_opdec.sv
// Combinational RV32 main-control decoder: instruction word -> control bundle plus illegal flag.
// Illegal encodings always produce an all-zero bundle.
module ctrl_opdec
    import decode_ctrl_stage_pkg::*;
#(
    parameter bit EN_UTYPE  = 1'b1,
    parameter bit EN_MULDIV = 1'b0
) (
    input  logic [31:0] i_instr,
    output ctrl_t       o_ctrl,
    output logic        o_illegal
);

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;
    logic       w_unused_fields;

    assign w_opcode = i_instr[6:0];
    assign w_funct3 = i_instr[14:12];
    assign w_funct7 = i_instr[31:25];
    assign w_unused_fields = ^{i_instr[24:15], i_instr[11:7]};

    // Opcode and funct-field decode into the control bundle
    always_comb begin
        o_ctrl    = '0;
        o_illegal = 1'b0;
        case (w_opcode)
            OP_LOAD:  o_ctrl = CTRL_LOAD;
            OP_STORE: o_ctrl = CTRL_STORE;
            OP_IALU:  o_ctrl = CTRL_IALU;
            OP_JAL:   o_ctrl = CTRL_JAL;
            OP_RTYPE: begin
                if ((w_funct7 == F7_BASE) || (w_funct7 == F7_ALT)) begin
                    o_ctrl = CTRL_RTYPE;
                end else if ((w_funct7 == F7_MULDIV) && EN_MULDIV) begin
                    o_ctrl = CTRL_MULDIV;
                end else begin
                    o_illegal = 1'b1;
                end
            end
            OP_BRANCH: begin
                if (branch_f3_bad(w_funct3)) begin
                    o_illegal = 1'b1;
                end else begin
                    o_ctrl = CTRL_BRANCH;
                end
            end
            OP_JALR: begin
                if (w_funct3 == 3'b000) begin
                    o_ctrl = CTRL_JALR;
                end else begin
                    o_illegal = 1'b1;
                end
            end
            OP_LUI: begin
                if (EN_UTYPE) begin
                    o_ctrl = CTRL_LUI;
                end else begin
                    o_illegal = 1'b1;
                end
            end
            OP_AUIPC: begin
                if (EN_UTYPE) begin
                    o_ctrl = CTRL_AUIPC;
                end else begin
                    o_illegal = 1'b1;
                end
            end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/decode_ctrl_stage.sv
// Registered RV32 main-control decode stage: one-entry valid/ready register with flush,
// accepted-instruction counter and sticky illegal status.
module decode_ctrl_stage #(
    parameter bit EN_UTYPE  = 1'b1,
    parameter bit EN_MULDIV = 1'b0,
    parameter int PC_W      = 32,
    parameter int CNT_W     = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    decode_ctrl_stage_if.slave  bus
);
    import decode_ctrl_stage_pkg::*;

    ctrl_t            w_ctrl;
    logic             w_illegal;
    logic             w_in_ready;
    logic             w_accept;

    logic             r_valid;
    ctrl_t            r_ctrl;
    logic             r_illegal;
    logic             r_sticky;
    logic [CNT_W-1:0] r_count;
    logic [PC_W-1:0]  r_pc;
    logic [2:0]       r_funct3;

    ctrl_opdec #(
        .EN_UTYPE  (EN_UTYPE),
        .EN_MULDIV (EN_MULDIV)
    ) u_opdec (
        .i_instr   (bus.instr),
        .o_ctrl    (w_ctrl),
        .o_illegal (w_illegal)
    );

    assign w_in_ready = !r_valid || bus.out_ready;
    assign w_accept   = bus.in_valid && w_in_ready && !flush;

    // Pipeline register: reset beats flush, flush beats both accept and drain
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid   <= 1'b0;
            r_ctrl    <= '0;
            r_illegal <= 1'b0;
            r_sticky  <= 1'b0;
            r_count   <= '0;
            r_pc      <= '0;
            r_funct3  <= 3'b000;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid   <= 1'b1;
            r_ctrl    <= w_ctrl;
            r_illegal <= w_illegal;
            r_sticky  <= r_sticky | w_illegal;
            r_count   <= r_count + CNT_W'(1);
            r_pc      <= bus.in_pc;
            r_funct3  <= bus.instr[14:12];
        end else if (bus.out_ready) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= r_valid;
        end
    end

    assign bus.in_ready       = w_in_ready;
    assign bus.out_valid      = r_valid;
    assign bus.out_pc         = r_pc;
    assign bus.out_funct3     = r_funct3;
    assign bus.RegWrite       = r_ctrl.reg_write;
    assign bus.ImmSrc         = r_ctrl.imm_src;
    assign bus.ALUSrc         = r_ctrl.alu_src;
    assign bus.ALUSrcA        = r_ctrl.alu_src_a;
    assign bus.MemWrite       = r_ctrl.mem_write;
    assign bus.ResultSrc      = r_ctrl.result_src;
    assign bus.Branch         = r_ctrl.branch;
    assign bus.ALUOp          = r_ctrl.alu_op;
    assign bus.Jump           = r_ctrl.jump;
    assign bus.JumpReg        = r_ctrl.jump_reg;
    assign bus.illegal        = r_illegal;
    assign bus.illegal_sticky = r_sticky;
    assign bus.decode_count   = r_count;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Scoreboard bench for decode_ctrl_stage: two parameterisations driven by one stimulus stream.
module tb_decode_ctrl_stage;

    logic        clk = 1'b0;
    logic        tb_reset = 1'b1;
    logic        tb_flush = 1'b0;
    logic        tb_in_valid = 1'b0;
    logic        tb_out_ready = 1'b0;
    logic [31:0] tb_instr = 32'h0;
    logic [31:0] tb_in_pc = 32'h0;

    always #5 clk = ~clk;

    decode_ctrl_stage_if #(.PC_W(32), .CNT_W(16)) ifa ();
    decode_ctrl_stage_if #(.PC_W(32), .CNT_W(4))  ifb ();

    assign ifa.in_valid  = tb_in_valid;
    assign ifa.instr     = tb_instr;
    assign ifa.in_pc     = tb_in_pc;
    assign ifa.out_ready = tb_out_ready;
    assign ifb.in_valid  = tb_in_valid;
    assign ifb.instr     = tb_instr;
    assign ifb.in_pc     = tb_in_pc;
    assign ifb.out_ready = tb_out_ready;

    decode_ctrl_stage #(.EN_UTYPE(1'b1), .EN_MULDIV(1'b0), .PC_W(32), .CNT_W(16)) dut_a (
        .clk(clk), .reset(tb_reset), .flush(tb_flush), .bus(ifa.slave));
    decode_ctrl_stage #(.EN_UTYPE(1'b0), .EN_MULDIV(1'b1), .PC_W(32), .CNT_W(4)) dut_b (
        .clk(clk), .reset(tb_reset), .flush(tb_flush), .bus(ifb.slave));

    // {illegal, RegWrite, ImmSrc, ALUSrc, ALUSrcA, MemWrite, ResultSrc, Branch, ALUOp, Jump, JumpReg}
    wire [14:0] a_bits = {ifa.illegal, ifa.RegWrite, ifa.ImmSrc, ifa.ALUSrc, ifa.ALUSrcA, ifa.MemWrite,
                          ifa.ResultSrc, ifa.Branch, ifa.ALUOp, ifa.Jump, ifa.JumpReg};
    wire [14:0] b_bits = {ifb.illegal, ifb.RegWrite, ifb.ImmSrc, ifb.ALUSrc, ifb.ALUSrcA, ifb.MemWrite,
                          ifb.ResultSrc, ifb.Branch, ifb.ALUOp, ifb.Jump, ifb.JumpReg};

    typedef struct packed {
        logic [31:0] pc;
        logic [2:0]  f3;
        logic [14:0] bits;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t m_ea, m_eb;
    int   n_tests = 0;
    int   n_fail = 0;
    int   exp_cnt = 0;
    bit   exp_sticky_a = 1'b0;
    bit   exp_sticky_b = 1'b0;
    logic [6:0] ops [0:9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Hand-written decode table, {illegal, 14 control bits in table column order}
    function automatic logic [14:0] model(input logic [31:0] ins, input bit en_u, input bit en_m);
        logic [2:0] f3;
        logic [6:0] f7;
        f3 = ins[14:12];
        f7 = ins[31:25];
        case (ins[6:0])
            7'b0000011: return {1'b0, 14'b1_000_1_0_0_01_0_00_0_0};
            7'b0100011: return {1'b0, 14'b0_001_1_0_1_00_0_00_0_0};
            7'b0010011: return {1'b0, 14'b1_000_1_0_0_00_0_10_0_0};
            7'b1101111: return {1'b0, 14'b1_011_0_0_0_10_0_00_1_0};
            7'b0110011: begin
                if (f7 == 7'b0000000 || f7 == 7'b0100000) return {1'b0, 14'b1_000_0_0_0_00_0_10_0_0};
                if (f7 == 7'b0000001 && en_m)              return {1'b0, 14'b1_000_0_0_0_00_0_11_0_0};
                return 15'h4000;
            end
            7'b1100011: return (f3 == 3'b010 || f3 == 3'b011) ? 15'h4000 : {1'b0, 14'b0_010_0_0_0_00_1_01_0_0};
            7'b1100111: return (f3 == 3'b000) ? {1'b0, 14'b1_000_1_0_0_10_0_00_1_1} : 15'h4000;
            7'b0110111: return en_u ? {1'b0, 14'b1_100_0_0_0_11_0_00_0_0} : 15'h4000;
            7'b0010111: return en_u ? {1'b0, 14'b1_100_1_1_0_00_0_00_0_0} : 15'h4000;
            default:    return 15'h4000;
        endcase
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        tb_reset = 1'b1;
        repeat (n) cyc();
        tb_reset = 1'b0;
        exp_cnt = 0;
        exp_sticky_a = 1'b0;
        exp_sticky_b = 1'b0;
    endtask

    // Present one instruction until accepted; expected bundles are queued at the accepting edge
    task automatic send(input logic [31:0] ins, input logic [31:0] pc, input bit rnd);
        int k;
        logic [14:0] ma, mb;
        tb_instr = ins;
        tb_in_pc = pc;
        tb_in_valid = 1'b1;
        for (k = 0; k < 60; k++) begin
            @(negedge clk);
            if (ifa.in_ready === 1'b1 && !tb_flush) break;
            @(posedge clk);
            #1;
            if (rnd) tb_out_ready = 1'($urandom_range(0, 1));
        end
        if (k == 60) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: instr %08h not accepted within 60 cycles", ins);
            tb_in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        ma = model(ins, 1'b1, 1'b0);
        mb = model(ins, 1'b0, 1'b1);
        q_a.push_back({pc, ins[14:12], ma});
        q_b.push_back({pc, ins[14:12], mb});
        exp_cnt++;
        exp_sticky_a = exp_sticky_a | ma[14];
        exp_sticky_b = exp_sticky_b | mb[14];
        #1;
        tb_in_valid = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_a_valid"}, ifa.out_valid, 0);
        chk({tag, "_a_bits"}, a_bits, 0);
        chk({tag, "_a_sticky"}, ifa.illegal_sticky, 0);
        chk({tag, "_a_count"}, ifa.decode_count, 0);
        chk({tag, "_a_pc_f3"}, {ifa.out_pc, ifa.out_funct3}, 0);
        chk({tag, "_b_valid"}, ifb.out_valid, 0);
        chk({tag, "_b_bits"}, b_bits, 0);
        chk({tag, "_b_sticky_count"}, {ifb.illegal_sticky, ifb.decode_count}, 0);
    endtask

    // Monitor: pop and compare on every transfer; flushed entries are dropped, reset empties the queues
    always @(negedge clk) begin
        if (tb_reset) begin
            q_a.delete();
            q_b.delete();
        end else if (tb_flush) begin
            if (ifa.out_valid && q_a.size() > 0) void'(q_a.pop_front());
            if (ifb.out_valid && q_b.size() > 0) void'(q_b.pop_front());
        end else begin
            if (ifa.out_valid && tb_out_ready) begin
                if (q_a.size() == 0) begin
                    chk("a_unexpected_out", 1, 0);
                end else begin
                    m_ea = q_a.pop_front();
                    chk("a_bundle", a_bits, m_ea.bits);
                    chk("a_pc", ifa.out_pc, m_ea.pc);
                    chk("a_funct3", ifa.out_funct3, m_ea.f3);
                end
            end
            if (ifb.out_valid && tb_out_ready) begin
                if (q_b.size() == 0) begin
                    chk("b_unexpected_out", 1, 0);
                end else begin
                    m_eb = q_b.pop_front();
                    chk("b_bundle", b_bits, m_eb.bits);
                    chk("b_pc", ifb.out_pc, m_eb.pc);
                    chk("b_funct3", ifb.out_funct3, m_eb.f3);
                end
            end
        end
    end

    initial begin
        logic [31:0] vecs [0:8];
        logic [31:0] ins;
        int saved;
        ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b1100011, 7'b0010011,
                7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1111111};
        vecs = '{32'h000010B7, 32'h0020C063, 32'h00002063, 32'h000080E7, 32'h000090E7,
                 32'h008000EF, 32'h00100093, 32'h402081B3, 32'h0000007F};

        // 1: reset state, then a load
        do_reset(3);
        chk_zero("reset");
        tb_out_ready = 1'b1;
        send(32'h00002083, 32'h100, 1'b0);
        chk("t1_valid", ifa.out_valid, 1);
        chk("t1_regwrite_alusrc", {ifa.RegWrite, ifa.ALUSrc}, 2'b11);
        chk("t1_resultsrc", ifa.ResultSrc, 2'b01);
        chk("t1_count", ifa.decode_count, 1);
        cyc();

        // 2: store held for 4 cycles while the next instruction waits
        tb_out_ready = 1'b0;
        send(32'h00112023, 32'h104, 1'b0);
        tb_instr = 32'h00100093;
        tb_in_pc = 32'h108;
        tb_in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t2_in_ready_low", ifa.in_ready, 0);
            chk("t2_hold", {ifa.out_valid, ifa.MemWrite, ifa.ImmSrc, ifa.out_pc}, {1'b1, 1'b1, 3'b001, 32'h104});
            chk("t2_count", ifa.decode_count, 2);
            cyc();
        end
        tb_out_ready = 1'b1;
        send(32'h00100093, 32'h108, 1'b0);
        chk("t2_count_after", ifa.decode_count, 3);
        cyc();

        // 3: auipc legal only with U-type enabled
        send(32'h00000097, 32'h200, 1'b0);
        chk("t3_a_auipc", {ifa.illegal, ifa.ALUSrcA, ifa.ImmSrc}, {1'b0, 1'b1, 3'b100});
        chk("t3_b_illegal", b_bits, 15'h4000);
        chk("t3_b_sticky", ifb.illegal_sticky, 1);
        cyc();

        // 4: mul legal only with M-extension enabled
        send(32'h021080B3, 32'h204, 1'b0);
        chk("t4_a_illegal", a_bits, 15'h4000);
        chk("t4_a_sticky", ifa.illegal_sticky, 1);
        chk("t4_b_mul", {ifb.illegal, ifb.ALUOp, ifb.RegWrite}, {1'b0, 2'b11, 1'b1});
        cyc();

        // back-to-back directed vectors through the scoreboard
        for (int i = 0; i < 9; i++) send(vecs[i], 32'h208 + 32'(i * 4), 1'b0);
        repeat (2) cyc();
        chk("vec_count_a", ifa.decode_count, exp_cnt);
        chk("vec_sticky", {ifa.illegal_sticky, ifb.illegal_sticky}, {exp_sticky_a, exp_sticky_b});

        // 5: flush while holding with a same-cycle input
        tb_out_ready = 1'b0;
        send(32'h00100093, 32'h300, 1'b0);
        saved = exp_cnt;
        tb_instr = 32'h00112023;
        tb_in_valid = 1'b1;
        tb_flush = 1'b1;
        cyc();
        tb_flush = 1'b0;
        tb_in_valid = 1'b0;
        chk("t5_flush_valid", {ifa.out_valid, ifb.out_valid}, 2'b00);
        chk("t5_flush_count", ifa.decode_count, saved);
        chk("t5_flush_sticky", {ifa.illegal_sticky, ifb.illegal_sticky}, {exp_sticky_a, exp_sticky_b});
        cyc();
        chk("t5_still_empty", ifa.out_valid, 0);

        // reset in the middle of a hold discards the entry
        send(32'h00002083, 32'h400, 1'b0);
        cyc();
        chk("t5_held", ifa.out_valid, 1);
        do_reset(1);
        chk_zero("midhold_reset");

        // 6: 2^4+3 accepts with random backpressure; 4-bit counter wraps to 3
        tb_out_ready = 1'b1;
        for (int i = 0; i < 19; i++) begin
            ins = $urandom;
            ins[6:0] = ops[$urandom_range(0, 9)];
            if (ins[6:0] == 7'b0110011) begin
                case ($urandom_range(0, 3))
                    0: ins[31:25] = 7'b0000000;
                    1: ins[31:25] = 7'b0100000;
                    2: ins[31:25] = 7'b0000001;
                    default: ins[31:25] = 7'b0000101;
                endcase
            end
            send(ins, 32'h1000 + 32'(i * 4), 1'b1);
            if ($urandom_range(0, 3) == 0) cyc();
        end
        tb_out_ready = 1'b1;
        repeat (3) cyc();
        chk("t6_count_a", ifa.decode_count, 19);
        chk("t6_count_b_wrap", ifb.decode_count, 3);
        chk("t6_sticky", {ifa.illegal_sticky, ifb.illegal_sticky}, {exp_sticky_a, exp_sticky_b});
        chk("t6_queues_empty", q_a.size() + q_b.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
